// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, with a fetch starvation limit.
// Optional ISSUE timeout abort is compiled in with MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    output logic                    o_if_gnt,
    output logic                    o_if_rvalid,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,
    input  logic                    i_ls_req,
    input  logic                    i_ls_we,
    input  logic [ADDR_WIDTH-1:0]   i_ls_addr,
    input  logic [DATA_WIDTH-1:0]   i_ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_ls_be,
    output logic                    o_ls_gnt,
    output logic                    o_ls_rvalid,
    output logic [DATA_WIDTH-1:0]   o_ls_rdata,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    input  logic                    i_mem_ack,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic                    o_err
);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state, state_nx;
    logic                  owner_ls;
    logic [SC_W-1:0]       starve_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  starved, if_win, ls_win, grant_en, take, timeout;

    assign starved  = starve_cnt >= SC_W'(STARVE_LIMIT);
    assign if_win   = i_if_req && (!i_ls_req || starved);
    assign ls_win   = i_ls_req && !if_win;
    assign grant_en = (state == IDLE) && !i_rst;
    assign take     = (state == IDLE) && (if_win || ls_win);

    assign o_if_gnt    = grant_en && if_win;
    assign o_ls_gnt    = grant_en && ls_win;
    assign o_mem_req   = (state == ISSUE);
    assign o_if_rvalid = (state == RESP) && !owner_ls;
    assign o_ls_rvalid = (state == RESP) && owner_ls;
    assign o_if_rdata  = o_if_rvalid ? rdata_q : '0;
    assign o_ls_rdata  = o_ls_rvalid ? rdata_q : '0;
    assign o_err       = (state == RESP) && err_q;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TC_W-1:0] tmo_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                tmo_cnt <= '0;
        else if (state != ISSUE)  tmo_cnt <= '0;
        else                      tmo_cnt <= tmo_cnt + 1'b1;
    end

    // An ack in the last allowed cycle takes precedence over the abort.
    assign timeout = (state == ISSUE) && !i_mem_ack && (tmo_cnt == TC_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (if_win || ls_win) state_nx = ISSUE;
            ISSUE:   if (i_mem_ack || timeout) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            owner_ls    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_be    <= '0;
        end else if (take) begin
            owner_ls    <= ls_win;
            o_mem_we    <= ls_win && i_ls_we;
            o_mem_addr  <= ls_win ? i_ls_addr : i_if_addr;
            o_mem_wdata <= ls_win ? i_ls_wdata : '0;
            o_mem_be    <= ls_win ? i_ls_be : '1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state == ISSUE && i_mem_ack) begin
            rdata_q <= o_mem_we ? '0 : i_mem_rdata;
            err_q   <= 1'b0;
        end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end
    end

    // Counts LSU wins over a waiting fetch; saturates so fetch keeps priority until served.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                  starve_cnt <= '0;
        else if (o_if_gnt)                          starve_cnt <= '0;
        else if (o_ls_gnt && i_if_req && !starved)  starve_cnt <= starve_cnt + 1'b1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: responses are scoreboarded, bus-side behaviour checked inline.
module tb_mem_arbiter;
    logic        i_clk = 1'b0, i_rst = 1'b1;
    logic        i_if_req = 1'b0, i_ls_req = 1'b0, i_ls_we = 1'b0, i_mem_ack = 1'b0;
    logic [31:0] i_if_addr = '0, i_ls_addr = '0, i_ls_wdata = '0, i_mem_rdata = '0;
    logic [3:0]  i_ls_be = '0;
    logic        o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid, o_mem_req, o_mem_we, o_err;
    logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;

    typedef struct packed {
        logic        ls;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_vec = 0, n_err = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
        .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
        .i_ls_wdata(i_ls_wdata), .i_ls_be(i_ls_be), .o_ls_gnt(o_ls_gnt),
        .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic ls, input logic [31:0] d, input logic err);
        exp_t e;
        e.ls = ls; e.rdata = d; e.err = err;
        sbq.push_back(e);
    endtask

    task automatic cyc();
        @(posedge i_clk); #1;
    endtask

    task automatic neg();
        @(negedge i_clk);
    endtask

    // Response monitor: every rvalid must match the oldest scoreboard entry.
    always @(negedge i_clk) begin
        if (o_if_gnt || o_ls_gnt)
            chk("gnt_excl", 64'(o_if_gnt & o_ls_gnt), 64'(0));
        if (o_if_rvalid || o_ls_rvalid) begin
            chk("rv_excl", 64'(o_if_rvalid & o_ls_rvalid), 64'(0));
            chk("rv_expected", 64'(sbq.size() > 0), 64'(1));
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("rv_owner_ls", 64'(o_ls_rvalid), 64'(mon_e.ls));
                chk("rv_rdata", 64'(o_ls_rvalid ? o_ls_rdata : o_if_rdata), 64'(mon_e.rdata));
                chk("rv_err", 64'(o_err), 64'(mon_e.err));
            end
        end else begin
            chk("err_without_rv", 64'(o_err), 64'(0));
        end
    end

    // One full transaction with requests already driven; acks on the first ISSUE cycle.
    task automatic xact(input logic exp_ls, input logic [31:0] d);
        neg();
        chk("arb_ls_gnt", 64'(o_ls_gnt), 64'(exp_ls));
        chk("arb_if_gnt", 64'(o_if_gnt), 64'(!exp_ls));
        cyc();
        i_mem_ack = 1'b1; i_mem_rdata = d;
        push_exp(exp_ls, d, 1'b0);
        neg();
        chk("arb_addr", 64'(o_mem_addr), exp_ls ? 64'h300 : 64'h108);
        cyc();
        i_mem_ack = 1'b0;
        cyc();
    endtask

    initial begin
        int cnt;
        logic exp_seq [6];
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state, with a fetch request asserted to confirm grants are held off
        i_if_req = 1'b1; i_if_addr = 32'h40;
        cyc(); neg();
        chk("rst_mem_req", 64'(o_mem_req), 64'(0));
        chk("rst_if_gnt", 64'(o_if_gnt), 64'(0));
        chk("rst_rvalid", 64'({o_if_rvalid, o_ls_rvalid}), 64'(0));
        chk("rst_err", 64'(o_err), 64'(0));
        chk("rst_addr", 64'(o_mem_addr), 64'(0));
        chk("rst_rdata", 64'({o_if_rdata, o_ls_rdata}), 64'(0));
        cyc();
        i_if_req = 1'b0; i_rst = 1'b0;
        cyc();

        // Fetch only, ack at c3
        i_if_req = 1'b1; i_if_addr = 32'h100;
        neg();
        chk("t1_if_gnt", 64'(o_if_gnt), 64'(1));
        chk("t1_mem_req_c0", 64'(o_mem_req), 64'(0));
        cyc(); i_if_req = 1'b0; neg();
        chk("t1_mem_req_c1", 64'(o_mem_req), 64'(1));
        chk("t1_addr", 64'(o_mem_addr), 64'h100);
        chk("t1_we", 64'(o_mem_we), 64'(0));
        cyc(); neg();
        chk("t1_mem_req_c2", 64'(o_mem_req), 64'(1));
        cyc();
        i_mem_ack = 1'b1; i_mem_rdata = 32'h00500093;
        push_exp(1'b0, 32'h00500093, 1'b0);
        neg();
        chk("t1_mem_req_c3", 64'(o_mem_req), 64'(1));
        cyc(); i_mem_ack = 1'b0; neg();
        chk("t1_if_rvalid", 64'(o_if_rvalid), 64'(1));
        chk("t1_mem_req_c4", 64'(o_mem_req), 64'(0));
        cyc();

        // Simultaneous store and fetch: LSU first, fetch in the next IDLE
        i_ls_req = 1'b1; i_ls_we = 1'b1; i_ls_addr = 32'h200; i_ls_wdata = 32'hDEADBEEF; i_ls_be = 4'hF;
        i_if_req = 1'b1; i_if_addr = 32'h104;
        neg();
        chk("t2_ls_gnt", 64'(o_ls_gnt), 64'(1));
        chk("t2_if_gnt", 64'(o_if_gnt), 64'(0));
        cyc();
        i_ls_req = 1'b0; i_ls_we = 1'b0;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h12345678;
        push_exp(1'b1, 32'h0, 1'b0);
        neg();
        chk("t2_we", 64'(o_mem_we), 64'(1));
        chk("t2_addr", 64'(o_mem_addr), 64'h200);
        chk("t2_wdata", 64'(o_mem_wdata), 64'hDEADBEEF);
        chk("t2_be", 64'(o_mem_be), 64'hF);
        chk("t2_if_wait", 64'(o_if_gnt), 64'(0));
        cyc(); i_mem_ack = 1'b0; neg();
        chk("t2_ls_rvalid", 64'(o_ls_rvalid), 64'(1));
        chk("t2_if_wait_resp", 64'(o_if_gnt), 64'(0));
        cyc(); neg();
        chk("t2_if_gnt", 64'(o_if_gnt), 64'(1));
        cyc();
        i_if_req = 1'b0;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h00000013;
        push_exp(1'b0, 32'h13, 1'b0);
        neg();
        chk("t2_if_addr", 64'(o_mem_addr), 64'h104);
        chk("t2_if_we", 64'(o_mem_we), 64'(0));
        cyc(); i_mem_ack = 1'b0; neg();
        chk("t2_if_rvalid", 64'(o_if_rvalid), 64'(1));
        cyc();

        // Starvation: both held; LSU x4, fetch, LSU
        i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h300; i_ls_wdata = '0;
        i_if_req = 1'b1; i_if_addr = 32'h108;
        for (int i = 0; i < 6; i++) xact(exp_seq[i], 32'hA0 + 32'(i));
        i_ls_req = 1'b0; i_if_req = 1'b0;
        cyc();

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout with no ack
        i_ls_req = 1'b1; i_ls_addr = 32'h400;
        neg();
        chk("t4_ls_gnt", 64'(o_ls_gnt), 64'(1));
        push_exp(1'b1, 32'h0, 1'b1);
        cyc(); i_ls_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            neg();
            if (!o_mem_req) break;
            cnt++;
            @(posedge i_clk); #1;
        end
        chk("t4_req_cycles", 64'(cnt), 64'(8));
        chk("t4_ls_rvalid", 64'(o_ls_rvalid), 64'(1));
        chk("t4_err", 64'(o_err), 64'(1));
        cyc();

        // Ack in the final timeout cycle completes normally
        i_ls_req = 1'b1; i_ls_addr = 32'h404;
        neg();
        chk("t6_ls_gnt", 64'(o_ls_gnt), 64'(1));
        cyc(); i_ls_req = 1'b0;
        repeat (7) cyc();
        i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE0001;
        push_exp(1'b1, 32'hCAFE0001, 1'b0);
        neg();
        chk("t6_mem_req", 64'(o_mem_req), 64'(1));
        cyc(); i_mem_ack = 1'b0; neg();
        chk("t6_ls_rvalid", 64'(o_ls_rvalid), 64'(1));
        chk("t6_err", 64'(o_err), 64'(0));
        cyc();
`else
        // No timeout: request stays up indefinitely; reset clears it
        i_ls_req = 1'b1; i_ls_addr = 32'h400;
        neg();
        chk("t4_ls_gnt", 64'(o_ls_gnt), 64'(1));
        cyc(); i_ls_req = 1'b0;
        repeat (100) cyc();
        neg();
        chk("t4_req_held", 64'(o_mem_req), 64'(1));
        chk("t4_err", 64'(o_err), 64'(0));
        cyc();
        i_rst = 1'b1; #1;
        chk("t4_rst_req", 64'(o_mem_req), 64'(0));
        cyc(); i_rst = 1'b0;
        cyc();
`endif

        // Reset in ISSUE: bus request drops at once, nothing comes back
        i_if_req = 1'b1; i_if_addr = 32'h500;
        neg();
        chk("t5_if_gnt", 64'(o_if_gnt), 64'(1));
        cyc(); i_if_req = 1'b0; neg();
        chk("t5_mem_req", 64'(o_mem_req), 64'(1));
        cyc();
        i_rst = 1'b1; i_ls_req = 1'b1; i_ls_addr = 32'h300;
        #1;
        chk("t5_req_drop", 64'(o_mem_req), 64'(0));
        chk("t5_gnt_in_rst", 64'(o_ls_gnt), 64'(0));
        neg();
        chk("t5_no_rvalid", 64'({o_if_rvalid, o_ls_rvalid}), 64'(0));
        cyc(); cyc();
        i_rst = 1'b0; i_ls_req = 1'b0;
        neg();
        chk("t5_idle_req", 64'(o_mem_req), 64'(0));
        cyc();
        i_if_req = 1'b1; i_if_addr = 32'h600;
        neg();
        chk("t5_post_gnt", 64'(o_if_gnt), 64'(1));
        cyc();
        i_if_req = 1'b0;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h77;
        push_exp(1'b0, 32'h77, 1'b0);
        neg();
        chk("t5_post_addr", 64'(o_mem_addr), 64'h600);
        cyc(); i_mem_ack = 1'b0; neg();
        chk("t5_post_rvalid", 64'(o_if_rvalid), 64'(1));
        cyc();

        // Starve counter restarted from 0 after reset: four LSU wins before fetch
        i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h300;
        i_if_req = 1'b1; i_if_addr = 32'h108;
        for (int i = 0; i < 5; i++) xact(exp_seq[i], 32'hB0 + 32'(i));
        i_ls_req = 1'b0; i_if_req = 1'b0;
        repeat (3) cyc();
        chk("sb_drained", 64'(sbq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
